// File: rtl/stack_pkg.sv
// stack_pkg: command encodings, ALU function codes and FSM states for the stack unit.
package stack_pkg;
    typedef enum logic [2:0] {
        CMD_PUSH = 3'd0,
        CMD_POP  = 3'd1,
        CMD_ADD  = 3'd2,
        CMD_SUB  = 3'd3,
        CMD_INC  = 3'd4,
        CMD_DEC  = 3'd5,
        CMD_DIV  = 3'd6,
        CMD_NOP  = 3'd7
    } cmd_e;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_INCX = 3'd2;
    localparam logic [2:0] ALU_DECX = 3'd3;
    localparam logic [2:0] ALU_INCY = 3'd4;
    localparam logic [2:0] ALU_DECY = 3'd5;
    localparam logic [2:0] ALU_DIV  = 3'd6;

    typedef enum logic {IDLE, EXEC} state_e;

    function automatic logic [2:0] alpha_of(input cmd_e c);
        return c == CMD_SUB ? ALU_SUB :
               c == CMD_DIV ? ALU_DIV :
               c == CMD_INC ? ALU_INCY :
               c == CMD_DEC ? ALU_DECY : ALU_ADD;
    endfunction
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: operand stack storage with depth pointer; push, pop, replace-TOS and
// pop-two-push-one are mutually exclusive single-edge operations.
module stack_regfile #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     replace_i,
    input  logic                     pop2push_i,
    input  logic [N-1:0]             wdata_i,
    output logic [N-1:0]             tos_o,
    output logic [N-1:0]             nos_o,
    output logic [$clog2(DEPTH):0]   depth_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] TWO = (AW+1)'(2);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW:0]   depth_q, depth_d;
    logic [AW-1:0] widx, tidx, nidx;

    always_comb begin
        tidx    = AW'(depth_q - ONE);
        nidx    = AW'(depth_q - TWO);
        depth_d = push_i ? depth_q + ONE : (pop_i || pop2push_i) ? depth_q - ONE : depth_q;
        widx    = push_i ? AW'(depth_q) : pop2push_i ? nidx : tidx;
    end

    always_ff @(posedge clk_i)
        if (push_i || replace_i || pop2push_i)
            mem_q[widx] <= wdata_i;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            depth_q <= '0;
        else
            depth_q <= depth_d;

    assign tos_o   = depth_q == '0 ? '0 : mem_q[tidx];
    assign nos_o   = depth_q < TWO ? '0 : mem_q[nidx];
    assign depth_o = depth_q;
endmodule

// File: rtl/stack_control_unit.sv
// stack_control_unit: command sequencer for the operand stack; drives a downstream
// combinational ALU and writes its result back after ALU_WAIT cycles.
module stack_control_unit
    import stack_pkg::*;
#(
    parameter int N        = 32,
    parameter int DEPTH    = 8,
    parameter int ALU_WAIT = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [2:0]             cmd_op_i,
    input  logic [N-1:0]           cmd_data_i,
    output logic [N-1:0]           alu_x_o,
    output logic [N-1:0]           alu_y_o,
    output logic [2:0]             alu_alpha_o,
    input  logic [N-1:0]           alu_z_i,
    input  logic                   alu_segno_i,
    output logic [N-1:0]           tos_o,
    output logic [$clog2(DEPTH):0] depth_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   segno_o,
    output logic                   done_o,
    output logic                   err_o
);
    localparam int DW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(ALU_WAIT + 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  alu_x_q, alu_y_q, nos;
    logic [2:0]    alu_alpha_q;
    logic          segno_q, done_q, err_q;
    cmd_e          op;
    logic          is_alu, is_bin, bad, accept, go, wb, unary_wb;
    logic          push, pop, replace, pop2push;

    always_comb begin
        op       = cmd_e'(cmd_op_i);
        is_bin   = op inside {CMD_ADD, CMD_SUB, CMD_DIV};
        is_alu   = is_bin || op inside {CMD_INC, CMD_DEC};
        bad      = (op == CMD_PUSH && full_o) || (op == CMD_POP && empty_o) ||
                   (is_bin && depth_o < DW'(2)) || (op == CMD_DIV && tos_o == '0) ||
                   (is_alu && empty_o);
        accept   = cmd_valid_i && cmd_ready_o;
        go       = accept && !bad;
        wb       = state_q == EXEC && cnt_q == '0;
        unary_wb = alu_alpha_q inside {ALU_INCY, ALU_DECY};
        push     = go && op == CMD_PUSH;
        pop      = go && op == CMD_POP;
        replace  = wb && unary_wb;
        pop2push = wb && !unary_wb;
    end

    stack_regfile #(.N(N), .DEPTH(DEPTH)) u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .pop_i      (pop),
        .replace_i  (replace),
        .pop2push_i (pop2push),
        .wdata_i    (push ? cmd_data_i : alu_z_i),
        .tos_o      (tos_o),
        .nos_o      (nos),
        .depth_o    (depth_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_alpha_q <= ALU_ADD;
            segno_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= wb || (go && !is_alu);
            err_q  <= accept && bad;
            if (state_q == IDLE) begin
                if (go && is_alu) begin
                    alu_x_q     <= nos;
                    alu_y_q     <= tos_o;
                    alu_alpha_q <= alpha_of(op);
                    cnt_q       <= CW'(ALU_WAIT - 1);
                    state_q     <= EXEC;
                end
            end else begin
                cnt_q <= cnt_q - CW'(1);
                if (wb) begin
                    segno_q <= alu_segno_i;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign cmd_ready_o = state_q == IDLE;
    assign alu_x_o     = alu_x_q;
    assign alu_y_o     = alu_y_q;
    assign alu_alpha_o = alu_alpha_q;
    assign empty_o     = depth_o == '0;
    assign full_o      = depth_o == DW'(DEPTH);
    assign segno_o     = segno_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_stack_control_unit.sv
// tb_stack_control_unit: directed vectors against stack_control_unit with a behavioural ALU
// attached downstream.
module tb_stack_control_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd7;
    logic [31:0] cmd_data = '0;
    logic [31:0] alu_x, alu_y, alu_z, tos;
    logic [2:0]  alu_alpha;
    logic        alu_segno, empty, full, segno, done, err;
    logic [3:0]  depth;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    stack_control_unit #(.N(32), .DEPTH(8), .ALU_WAIT(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .alu_x_o     (alu_x),
        .alu_y_o     (alu_y),
        .alu_alpha_o (alu_alpha),
        .alu_z_i     (alu_z),
        .alu_segno_i (alu_segno),
        .tos_o       (tos),
        .depth_o     (depth),
        .empty_o     (empty),
        .full_o      (full),
        .segno_o     (segno),
        .done_o      (done),
        .err_o       (err)
    );

    always_comb begin
        case (alu_alpha)
            3'd0:    alu_z = alu_x + alu_y;
            3'd1:    alu_z = alu_x - alu_y;
            3'd2:    alu_z = alu_x + 32'd1;
            3'd3:    alu_z = alu_x - 32'd1;
            3'd4:    alu_z = alu_y + 32'd1;
            3'd5:    alu_z = alu_y - 32'd1;
            3'd6:    alu_z = alu_y == 0 ? 32'd0 : alu_x / alu_y;
            default: alu_z = 32'd0;
        endcase
        alu_segno = ~alu_z[31];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one command for exactly one edge; returns 1 time unit after the acceptance edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, n, 2);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tos", tos, 0);
        check("rst_flags", {segno, done, err}, 0);
        check("rst_alu", {alu_x, alu_y, alu_alpha} == 0, 1);
        @(negedge clk) rst = 1'b0;

        issue(3'd0, 32'd5);
        check("push5_done", {done, err}, 2'b10);
        check("push5_tos", tos, 5);
        issue(3'd0, 32'd3);
        check("push3_depth", depth, 2);
        issue(3'd2, 0);
        check("add_x", alu_x, 5);
        check("add_y", alu_y, 3);
        check("add_alpha", alu_alpha, 0);
        check("add_busy", cmd_ready, 0);
        wait_done("add");
        check("add_tos", tos, 8);
        check("add_depth", depth, 1);
        check("add_segno", segno, 1);
        check("add_ready", cmd_ready, 1);
        @(posedge clk) #1;
        check("add_pulse", done, 0);
        issue(3'd7, 0);
        check("nop", {done, err, depth}, {2'b10, 4'd1});
        issue(3'd1, 0);

        issue(3'd0, 32'd3);
        issue(3'd0, 32'd5);
        issue(3'd3, 0);
        check("sub_alpha", alu_alpha, 1);
        wait_done("sub");
        check("sub_tos", tos, 32'hFFFF_FFFE);
        check("sub_segno", segno, 0);
        issue(3'd1, 0);

        issue(3'd0, 32'd7);
        issue(3'd0, 32'd0);
        issue(3'd6, 0);
        check("div0_err", {done, err}, 2'b01);
        check("div0_depth", depth, 2);
        check("div0_tos", tos, 0);
        check("div0_alpha", alu_alpha, 1);
        check("div0_ready", cmd_ready, 1);
        issue(3'd1, 0);
        issue(3'd1, 0);

        issue(3'd1, 0);
        check("pop_empty", {done, err, depth}, {2'b01, 4'd0});
        issue(3'd4, 0);
        check("inc_empty", {done, err, cmd_ready}, 3'b011);
        for (int i = 1; i <= 8; i++) issue(3'd0, i);
        check("full8", {full, depth}, {1'b1, 4'd8});
        issue(3'd0, 32'd99);
        check("push_full", {done, err, depth}, {2'b01, 4'd8});
        check("push_full_tos", tos, 8);
        for (int i = 0; i < 8; i++) issue(3'd1, 0);
        check("drained", empty, 1);

        issue(3'd0, 32'd9);
        issue(3'd4, 0);
        check("inc_alpha", alu_alpha, 4);
        wait_done("inc");
        check("inc_tos", {tos, depth}, {32'd10, 4'd1});
        issue(3'd5, 0);
        wait_done("dec1");
        issue(3'd5, 0);
        check("dec_alpha", alu_alpha, 5);
        wait_done("dec2");
        check("dec_tos", {tos, depth}, {32'd8, 4'd1});
        issue(3'd1, 0);

        issue(3'd0, 32'd4);
        issue(3'd0, 32'd2);
        issue(3'd6, 0);
        check("div_alpha", alu_alpha, 6);
        @(negedge clk) rst = 1'b1;
        #1;
        check("rst_mid_flags", {done, err, depth}, 0);
        @(negedge clk) rst = 1'b0;
        check("rst_mid_ready", cmd_ready, 1);
        repeat (3) begin
            @(posedge clk) #1;
            check("rst_mid_quiet", {done, err, depth}, 0);
        end
        issue(3'd0, 32'd1);
        check("post_rst_push", {tos, depth, done}, {32'd1, 4'd1, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
